fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 26 ++
 rtl/fetch_ctrl_if.sv | 13 +
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_fetch_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU package for the instruction fetch controller.
// Holds the fetch FSM state type, the reset PC default and the fetch output payload.
package fetch_ctrl_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_OUT  = 2'd2,
      S_HALT = 2'd3
   } fetch_state_e;

   // Instruction word handed to decode together with its address
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_pkt_t;

   // Word-align an address by clearing the byte offset
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between fetch (master) and memory (slave).
interface fetch_ctrl_if;
   import fetch_ctrl_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, redirect/kill handling.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets halt fetch instead of being word-aligned.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   fetch_ctrl_if.master    imem,
   input  logic            redir_valid,
   input  logic [XLEN-1:0] redir_target,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] pc,
   output logic            exc_misalign
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_q, pend_d;
   fetch_pkt_t      pkt_q, pkt_d;
   logic            kill_q, kill_d;
   logic            exc_q, exc_d;
   logic            req_q, req_d;
   logic            valid_q, valid_d;

   logic [XLEN-1:0] tgt_c;
   logic            fatal_c;

`ifdef FETCH_ALIGN_CHECK_EN
   assign tgt_c   = redir_target;
   assign fatal_c = redir_valid && (redir_target[1:0] != 2'b00);
`else
   assign tgt_c   = align_word(redir_target);
   assign fatal_c = 1'b0;
`endif

   // Next-state and datapath updates
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      pkt_d   = pkt_q;
      kill_d  = kill_q;
      exc_d   = exc_q;
      unique case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (fatal_c) begin
               exc_d   = 1'b1;
               kill_d  = 1'b0;
               state_d = S_HALT;
            end else if (imem.imem_ack) begin
               if (kill_q || redir_valid) begin
                  // Returned word belongs to the squashed path
                  pc_d   = redir_valid ? tgt_c : pend_q;
                  kill_d = 1'b0;
               end else begin
                  pkt_d   = '{instr: imem.imem_rdata, pc: pc_q};
                  state_d = S_OUT;
               end
            end else if (redir_valid) begin
               kill_d = 1'b1;
               pend_d = tgt_c;
            end
         end
         S_OUT: begin
            if (fatal_c) begin
               exc_d   = 1'b1;
               state_d = S_HALT;
            end else if (redir_valid) begin
               pc_d    = tgt_c;
               state_d = S_REQ;
            end else if (if_ready) begin
               pc_d    = pc_q + XLEN'(4);
               state_d = S_REQ;
            end
         end
`ifdef FETCH_ALIGN_CHECK_EN
         S_HALT: state_d = S_HALT;
`endif
         default: state_d = S_IDLE;
      endcase
      req_d   = (state_d == S_REQ);
      valid_d = (state_d == S_OUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         pend_q  <= '0;
         pkt_q   <= '{instr: '0, pc: RESET_PC};
         kill_q  <= 1'b0;
         exc_q   <= 1'b0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         pkt_q   <= pkt_d;
         kill_q  <= kill_d;
         exc_q   <= exc_d;
         req_q   <= req_d;
         valid_q <= valid_d;
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign if_valid       = valid_q;
   assign if_instr       = pkt_q.instr;
   assign if_pc          = pkt_q.pc;
   assign pc             = pc_q;
   assign exc_misalign   = exc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl: per-cycle stimulus/expectation table plus
// hand sequences for the misaligned-redirect and asynchronous-reset corner cases.
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redir_valid;
   logic [31:0] redir_target;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] pc;
   logic        exc_misalign;

   int n_vec = 0;
   int n_err = 0;

   fetch_ctrl_if imem_if ();

   fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem         (imem_if),
      .redir_valid  (redir_valid),
      .redir_target (redir_target),
      .if_valid     (if_valid),
      .if_ready     (if_ready),
      .if_instr     (if_instr),
      .if_pc        (if_pc),
      .pc           (pc),
      .exc_misalign (exc_misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ack;
      logic [31:0] rdata;
      logic        rv;
      logic [31:0] rt;
      logic        rdy;
      logic        e_req;
      logic        e_val;
      logic [31:0] e_instr;
      logic [31:0] e_ifpc;
      logic [31:0] e_pc;
   } vec_t;

   localparam int NV = 24;
   vec_t tbl [NV];

   localparam logic [31:0] I0 = 32'h1111_0000, I1 = 32'h2222_0004, I2 = 32'h3333_0008,
                           I3 = 32'hDEAD_BEEF, I4 = 32'h4444_3200, I5 = 32'hBAD0_BAD0,
                           I6 = 32'h6666_3300, I7 = 32'h7777_3400, I8 = 32'h8888_3000;

   function automatic vec_t mk(input logic ack, input logic [31:0] rd, input logic rv,
                               input logic [31:0] rt, input logic rdy, input logic req,
                               input logic val, input logic [31:0] ins, input logic [31:0] ipc,
                               input logic [31:0] p);
      vec_t v;
      v.ack = ack; v.rdata = rd; v.rv = rv; v.rt = rt; v.rdy = rdy;
      v.e_req = req; v.e_val = val; v.e_instr = ins; v.e_ifpc = ipc; v.e_pc = p;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ack, input logic [31:0] rd, input logic rv,
                        input logic [31:0] rt, input logic rdy);
      imem_if.imem_ack   = ack;
      imem_if.imem_rdata = rd;
      redir_valid        = rv;
      redir_target       = rt;
      if_ready           = rdy;
   endtask

   initial begin
      //            ack rdata rv  target        rdy  req val instr if_pc         pc
      tbl[0]  = mk(0, 0,  0, 0,            0,   1, 0, 0,  32'h3000, 32'h3000);
      tbl[1]  = mk(0, 0,  0, 0,            1,   1, 0, 0,  32'h3000, 32'h3000);
      tbl[2]  = mk(1, I0, 0, 0,            1,   0, 1, I0, 32'h3000, 32'h3000);
      tbl[3]  = mk(0, 0,  0, 0,            1,   1, 0, I0, 32'h3000, 32'h3004);
      tbl[4]  = mk(0, 0,  0, 0,            1,   1, 0, I0, 32'h3000, 32'h3004);
      tbl[5]  = mk(1, I1, 0, 0,            1,   0, 1, I1, 32'h3004, 32'h3004);
      tbl[6]  = mk(0, 0,  0, 0,            0,   0, 1, I1, 32'h3004, 32'h3004);
      tbl[7]  = mk(0, 0,  0, 0,            0,   0, 1, I1, 32'h3004, 32'h3004);
      tbl[8]  = mk(0, 0,  0, 0,            0,   0, 1, I1, 32'h3004, 32'h3004);
      tbl[9]  = mk(0, 0,  0, 0,            1,   1, 0, I1, 32'h3004, 32'h3008);
      tbl[10] = mk(0, 0,  0, 0,            1,   1, 0, I1, 32'h3004, 32'h3008);
      tbl[11] = mk(1, I2, 0, 0,            1,   0, 1, I2, 32'h3008, 32'h3008);
      tbl[12] = mk(0, 0,  1, 32'h3040,     1,   1, 0, I2, 32'h3008, 32'h3040);
      tbl[13] = mk(0, 0,  1, 32'h3100,     0,   1, 0, I2, 32'h3008, 32'h3040);
      tbl[14] = mk(0, 0,  1, 32'h3200,     0,   1, 0, I2, 32'h3008, 32'h3040);
      tbl[15] = mk(0, 0,  0, 0,            0,   1, 0, I2, 32'h3008, 32'h3040);
      tbl[16] = mk(1, I3, 0, 0,            0,   1, 0, I2, 32'h3008, 32'h3200);
      tbl[17] = mk(0, 0,  0, 0,            0,   1, 0, I2, 32'h3008, 32'h3200);
      tbl[18] = mk(1, I4, 0, 0,            0,   0, 1, I4, 32'h3200, 32'h3200);
      tbl[19] = mk(0, 0,  0, 0,            1,   1, 0, I4, 32'h3200, 32'h3204);
      tbl[20] = mk(1, I5, 1, 32'h3300,     0,   1, 0, I4, 32'h3200, 32'h3300);
      tbl[21] = mk(1, I6, 0, 0,            0,   0, 1, I6, 32'h3300, 32'h3300);
      tbl[22] = mk(0, 0,  1, 32'h3400,     0,   1, 0, I6, 32'h3300, 32'h3400);
      tbl[23] = mk(1, I7, 0, 0,            0,   0, 1, I7, 32'h3400, 32'h3400);

      // Reset with ack and redirect active: both must be ignored
      rst_n = 1'b0;
      drive(1, 32'hFFFF_FFFF, 1, 32'h3500, 1);
      step(); step();
      chk("rst.req",   32'(imem_if.imem_req), 32'd0);
      chk("rst.valid", 32'(if_valid), 32'd0);
      chk("rst.pc",    pc, 32'h3000);
      chk("rst.if_pc", if_pc, 32'h3000);
      chk("rst.instr", if_instr, 32'd0);
      chk("rst.exc",   32'(exc_misalign), 32'd0);

      drive(0, 0, 0, 0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].ack, tbl[i].rdata, tbl[i].rv, tbl[i].rt, tbl[i].rdy);
         step();
         chk($sformatf("v%0d.req", i),   32'(imem_if.imem_req), 32'(tbl[i].e_req));
         chk($sformatf("v%0d.valid", i), 32'(if_valid), 32'(tbl[i].e_val));
         chk($sformatf("v%0d.instr", i), if_instr, tbl[i].e_instr);
         chk($sformatf("v%0d.if_pc", i), if_pc, tbl[i].e_ifpc);
         chk($sformatf("v%0d.pc", i),    pc, tbl[i].e_pc);
         if (tbl[i].e_req) chk($sformatf("v%0d.addr", i), imem_if.imem_addr, tbl[i].e_pc);
         chk($sformatf("v%0d.exc", i),   32'(exc_misalign), 32'd0);
      end

      // Misaligned redirect taken from OUT with the instruction accepted
      drive(0, 0, 1, 32'h3042, 1);
      step();
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis.exc",   32'(exc_misalign), 32'd1);
      chk("mis.req",   32'(imem_if.imem_req), 32'd0);
      chk("mis.valid", 32'(if_valid), 32'd0);
      drive(1, I8, 1, 32'h3500, 1);
      step(); step();
      chk("halt.req",   32'(imem_if.imem_req), 32'd0);
      chk("halt.valid", 32'(if_valid), 32'd0);
      chk("halt.exc",   32'(exc_misalign), 32'd1);
      chk("halt.pc",    pc, 32'h3400);
`else
      chk("mis.exc",  32'(exc_misalign), 32'd0);
      chk("mis.req",  32'(imem_if.imem_req), 32'd1);
      chk("mis.addr", imem_if.imem_addr, 32'h3040);
`endif

      // Asynchronous reset while a request with a pending kill is outstanding
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("ar.req0",  32'(imem_if.imem_req), 32'd1);
      chk("ar.addr0", imem_if.imem_addr, 32'h3000);
      drive(0, 0, 1, 32'h3600, 0);
      step();
      chk("ar.kill_req", 32'(imem_if.imem_req), 32'd1);
      redir_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("ar.req_drop", 32'(imem_if.imem_req), 32'd0);
      chk("ar.pc",       pc, 32'h3000);
      chk("ar.exc",      32'(exc_misalign), 32'd0);
      drive(1, 32'hFFFF_FFFF, 1, 32'h3500, 0);
      step();
      chk("ar.held_req", 32'(imem_if.imem_req), 32'd0);
      chk("ar.held_val", 32'(if_valid), 32'd0);
      rst_n = 1'b1;
      step();
      chk("ar.idle_req",  32'(imem_if.imem_req), 32'd1);
      chk("ar.idle_addr", imem_if.imem_addr, 32'h3000);
      chk("ar.idle_val",  32'(if_valid), 32'd0);
      drive(1, I8, 0, 0, 0);
      step();
      chk("ar.out_val",   32'(if_valid), 32'd1);
      chk("ar.out_instr", if_instr, I8);
      chk("ar.out_if_pc", if_pc, 32'h3000);
      chk("ar.out_req",   32'(imem_if.imem_req), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
